// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller.
// Holds the FSM state codes, opcode/funct constants, ALU function codes
// and the instruction-class enum produced by the decoder.
package mips_ctrl_pkg;

  // FSM state codes (kept as plain constants for legacy tools)
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Datapath ALU function codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'd0,
    CLS_ALU_I   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: purely combinational instruction decoder.
// Ports:
//   ir             in  32  instruction register
//   cls            out  3  instruction class
//   alufunc        out  3  ALU function to use in EX
//   branch_on_zero out  1  1 for BEQZ, 0 for BNEZ (only meaningful for branches)
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_e cls,
  output logic [2:0]   alufunc,
  output logic         branch_on_zero
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_ir_bits_s;

  assign opcode_s = ir[31:26];
  assign funct_s  = ir[5:0];
  // Register and immediate fields belong to the datapath, not the controller
  assign unused_ir_bits_s = ^ir[25:6];

  // Opcode/funct to class, ALU function and branch sense
  always_comb begin
    cls            = CLS_ILLEGAL;
    alufunc        = ALU_ADD;
    branch_on_zero = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  begin cls = CLS_ALU_R; alufunc = ALU_ADD; end
          FN_SUB:  begin cls = CLS_ALU_R; alufunc = ALU_SUB; end
          FN_AND:  begin cls = CLS_ALU_R; alufunc = ALU_AND; end
          FN_OR:   begin cls = CLS_ALU_R; alufunc = ALU_OR;  end
          FN_SLT:  begin cls = CLS_ALU_R; alufunc = ALU_SLT; end
          default: begin cls = CLS_ILLEGAL; alufunc = ALU_ADD; end
        endcase
      end
      OP_ADDI: begin cls = CLS_ALU_I;  alufunc = ALU_ADD; end
      OP_SLTI: begin cls = CLS_ALU_I;  alufunc = ALU_SLT; end
      OP_LW:   begin cls = CLS_LOAD;   alufunc = ALU_ADD; end
      OP_SW:   begin cls = CLS_STORE;  alufunc = ALU_ADD; end
      // Branch target is NPC + Imm, so ADD for both senses
      OP_BEQZ: begin cls = CLS_BRANCH; alufunc = ALU_ADD; branch_on_zero = 1'b1; end
      OP_BNEZ: begin cls = CLS_BRANCH; alufunc = ALU_ADD; branch_on_zero = 1'b0; end
      OP_HLT:  begin cls = CLS_HALT;   alufunc = ALU_ADD; end
      default: begin cls = CLS_ILLEGAL; alufunc = ALU_ADD; end
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// mips_controller: multicycle IF/ID/EX/MEM/WB sequencer for the MIPS datapath.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        pulse in IDLE to begin execution
//   IRout, cond  instruction register and A==0 comparator from the datapath
//   Load*        register load enables
//   Mux*         datapath mux selects
//   ReadM/WriteM/WriteReg  memory and register-file strobes
//   Alufunc      ALU function code
//   busy/halted/illegal    status (illegal is sticky until reset)
// Outputs are combinational from the state register and IR decode, so an
// asynchronous reset clears every strobe without waiting for a clock.
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] IRout,
  input  logic        cond,
  output logic        LoadPC,
  output logic        LoadNPC,
  output logic        LoadIR,
  output logic        LoadA,
  output logic        LoadB,
  output logic        LoadImm,
  output logic        LoadALUout,
  output logic        LoadLMD,
  output logic        MuxALU1,
  output logic        MuxALU2,
  output logic        MuxPC,
  output logic        MuxmemRD,
  output logic        MuxWB,
  output logic        MuxRegeWr,
  output logic        ReadM,
  output logic        WriteM,
  output logic        WriteReg,
  output logic [2:0]  Alufunc,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  logic [2:0]   state_q, state_d;
  logic         illegal_q, illegal_d;
  instr_class_e cls_s;
  logic [2:0]   dec_alufunc_s;
  logic         dec_boz_s;

  mips_ctrl_decode u_decode (
    .ir             (IRout),
    .cls            (cls_s),
    .alufunc        (dec_alufunc_s),
    .branch_on_zero (dec_boz_s)
  );

  // Next-state and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_IF;
        else       state_d = S_IDLE;
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls_s)
          CLS_HALT:    state_d = S_HALT;
          CLS_ILLEGAL: begin state_d = S_HALT; illegal_d = 1'b1; end
          default:     state_d = S_EX;
        endcase
      end
      S_EX: begin
        if (cls_s == CLS_LOAD || cls_s == CLS_STORE || cls_s == CLS_BRANCH) state_d = S_MEM;
        else                                                                state_d = S_WB;
      end
      S_MEM: begin
        if (cls_s == CLS_LOAD) state_d = S_WB;
        else                   state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      // Unused encodings recover to IDLE
      default: state_d = S_IDLE;
    endcase
  end

  // State and illegal flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath control decode per state
  always_comb begin
    LoadPC = 1'b0; LoadNPC = 1'b0; LoadIR = 1'b0; LoadA = 1'b0;
    LoadB = 1'b0; LoadImm = 1'b0; LoadALUout = 1'b0; LoadLMD = 1'b0;
    MuxALU1 = 1'b0; MuxALU2 = 1'b0; MuxPC = 1'b0; MuxmemRD = 1'b0;
    MuxWB = 1'b0; MuxRegeWr = 1'b0;
    ReadM = 1'b0; WriteM = 1'b0; WriteReg = 1'b0;
    Alufunc = ALU_ADD;
    case (state_q)
      S_IF: begin
        ReadM = 1'b1; LoadIR = 1'b1; LoadNPC = 1'b1;
      end
      S_ID: begin
        LoadA = 1'b1; LoadB = 1'b1; LoadImm = 1'b1;
      end
      S_EX: begin
        LoadALUout = 1'b1;
        MuxALU1    = (cls_s != CLS_BRANCH);
        MuxALU2    = (cls_s != CLS_ALU_R);
        Alufunc    = dec_alufunc_s;
      end
      S_MEM: begin
        case (cls_s)
          CLS_LOAD:   begin ReadM = 1'b1; MuxmemRD = 1'b1; LoadLMD = 1'b1; end
          CLS_STORE:  begin WriteM = 1'b1; MuxmemRD = 1'b1; LoadPC = 1'b1; end
          // cond is live here: select the ALUout target only when taken
          CLS_BRANCH: begin LoadPC = 1'b1; MuxPC = dec_boz_s ? cond : ~cond; end
          default:    begin LoadPC = 1'b0; end
        endcase
      end
      S_WB: begin
        WriteReg  = 1'b1;
        LoadPC    = 1'b1;
        MuxWB     = (cls_s != CLS_LOAD);
        MuxRegeWr = (cls_s == CLS_ALU_R);
      end
      default: begin
        LoadPC = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                   (state_q == S_MEM) || (state_q == S_WB);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle sequencer for the MIPS datapath. It decodes the instruction register and cond flag, then steps each instruction through IF/ID/EX/MEM/WB. It drives every load strobe, mux select, memory strobe, register-write and ALU-function input of the datapath. It sits beside the datapath in the CPU top level, and is the only source of those control signals.

## Interface
- No parameters; encodings are fixed in `mips_ctrl_pkg`.
- clk  in  1  rising-edge clock shared with datapath
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- IRout  in  32  instruction register from datapath
- cond  in  1  datapath comparator (1 when A == 0)
- LoadPC, LoadNPC, LoadIR, LoadA, LoadB, LoadImm, LoadALUout, LoadLMD  out  1 each  register load enables
- MuxALU1  out  1  0 selects NPC, 1 selects A
- MuxALU2  out  1  0 selects B, 1 selects Imm
- MuxPC  out  1  0 selects NPC, 1 selects ALUout
- MuxmemRD  out  1  0 selects PC address, 1 selects ALUout
- MuxWB  out  1  0 selects LMD, 1 selects ALUout
- MuxRegeWr  out  1  0 selects rt = IR[20:16], 1 selects rd = IR[15:11]
- ReadM, WriteM, WriteReg  out  1 each  memory read, memory write, register-file write
- Alufunc  out  3  ADD=0, SUB=1, AND=2, OR=3, SLT=4
- busy  out  1  high in IF..WB
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when an undecodable instruction reaches ID

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT.
- Outputs are combinational from the state register and the IR decode. Any strobe not listed for a state is 0, and any mux not listed is 0.
- IDLE: waits for `start`, then goes to IF.
- IF: ReadM=1, MuxmemRD=0, LoadIR=1, LoadNPC=1. Next state is ID.
- ID: LoadA=1, LoadB=1, LoadImm=1. HLT (op 0x3F) goes to HALT. An illegal opcode or funct goes to HALT and sets `illegal`. Everything else goes to EX.
- Opcodes: R-type op 0x00 with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A. ADDI 0x08, SLTI 0x0A, LW 0x23, SW 0x2B, BEQZ 0x04, BNEZ 0x05.
- EX: LoadALUout=1 for every class.
  - R-type: MuxALU1=1, MuxALU2=0, Alufunc taken from funct.
  - ADDI/SLTI: MuxALU1=1, MuxALU2=1, Alufunc ADD or SLT.
  - LW/SW: MuxALU1=1, MuxALU2=1, Alufunc ADD.
  - Branch: MuxALU1=0, MuxALU2=1, Alufunc ADD (target = NPC + Imm).
  - ALU instructions then go to WB; LW, SW and branches go to MEM.
- MEM:
  - LW: ReadM=1, MuxmemRD=1, LoadLMD=1, then WB.
  - SW: WriteM=1, MuxmemRD=1, LoadPC=1 with MuxPC=0, then IF.
  - Branch: LoadPC=1 with MuxPC = taken, then IF. BEQZ taken = cond; BNEZ taken = ~cond. cond is sampled in MEM.
- WB: WriteReg=1, LoadPC=1, MuxPC=0, then IF.
  - R-type: MuxWB=1, MuxRegeWr=1.
  - ADDI/SLTI: MuxWB=1, MuxRegeWr=0.
  - LW: MuxWB=0, MuxRegeWr=0.
- HALT: absorbing; only reset leaves it. All strobes are 0 and `start` is ignored. PC is not advanced past HLT or an illegal instruction.
- IR is loaded only in IF, so decode stays stable for the whole instruction.

## Timing
- Cycles per instruction: ALU 4, LW 5, SW 4, branch 4, HLT/illegal 2 (then HALT).
- The first IF is the cycle after `start` is sampled high in IDLE.
- Memory read is combinational, so the IR and LMD loads complete on the same edge that ends IF or MEM.
- Reset forces state to IDLE and all outputs to 0 (including `illegal`, `busy`, `halted`) immediately, with no clock needed. A reset mid-instruction abandons it: no partial PC or register write happens after rst_n falls.
- A `start` pulse outside IDLE has no effect.

## Structure
- `mips_ctrl_pkg` holds the state enum, opcode and funct constants, Alufunc codes and an instruction-class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, HALT, ILLEGAL).
- Sub-module `mips_ctrl_decode` is purely combinational. It maps IRout to instruction class, Alufunc, and branch sense (BEQZ vs BNEZ).
- The top level holds the FSM and the output logic.

## Test plan
- Reset, pulse start, IR=0x00221820 (add r3,r1,r2):
  - IF: LoadIR=LoadNPC=ReadM=1.
  - EX: Alufunc=0, MuxALU1=1, MuxALU2=0.
  - WB: WriteReg=MuxWB=MuxRegeWr=LoadPC=1.
  - Returns to IF after 4 cycles.
- IR=0x8C430004 (lw r3,4(r2)):
  - MEM: ReadM=MuxmemRD=LoadLMD=1.
  - WB: MuxWB=0, MuxRegeWr=0.
  - Total 5 cycles.
- IR=0xAC430004 (sw): MEM has WriteM=1, WriteReg=0 throughout, 4 cycles.
- BEQZ 0x10400003:
  - cond=1 gives MuxPC=1 in MEM; cond=0 gives MuxPC=0.
  - BNEZ 0x14400003 with cond=1 gives MuxPC=0.
- IR=0xFC000000 (HLT): halted=1 from the third cycle, all strobes 0 for 20 cycles, start pulses ignored. IR=0xF8000000 gives halted=1 and illegal=1.
- rst_n low during EX of an add: all outputs 0 before the next edge, state IDLE, busy=0. Release and start: a clean IF follows.
